// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: decode-stage hazard tracker sitting in front of the
// 8x16 LC-3b register file. Keeps a pending-write count per architectural
// register, holds issue while any used source is still pending, and retires
// a pending write when writeback loads the regfile.
//
// Build option: define SCOREBOARD_WB_BYPASS_EN to let a reader issue in the
// same cycle as the writeback of its last pending producer (forwarding path).
// Without it, the reader waits until the regfile holds the value.
module regfile_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WAW_STALL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_writes,
  input  logic [2:0]       issue_dest,
  input  logic [2:0]       issue_src_a,
  input  logic [2:0]       issue_src_b,
  input  logic [2:0]       issue_memsr2,
  input  logic [2:0]       issue_use,
  input  logic             wb_valid,
  input  logic [2:0]       wb_dest,
  input  logic             flush,
  output logic [7:0]       busy_mask,
  output logic [CNT_W+2:0] inflight_total,
  output logic             err_underflow
);

  localparam int              TOT_W   = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       busy_q, busy_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             err_q, err_d;

  logic       hazard, sat, waw, fire, inc;
  logic [2:0] src_sel [3];

  assign src_sel[0] = issue_src_a;
  assign src_sel[1] = issue_src_b;
  assign src_sel[2] = issue_memsr2;

  // Any used source with a pending producer blocks issue
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (issue_use[i] && (cnt_q[src_sel[i]] != '0)) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Last pending producer retiring right now: value comes off the forwarding path
        if (!((cnt_q[src_sel[i]] == CNT_ONE) && wb_valid && (wb_dest == src_sel[i])))
          hazard = 1'b1;
`else
        hazard = 1'b1;
`endif
      end
    end
  end

  // Saturation keeps the counter from wrapping; it blocks the issue instead
  assign sat         = issue_writes && (cnt_q[issue_dest] == CNT_MAX);
  assign waw         = WAW_STALL && issue_writes && (cnt_q[issue_dest] != '0);
  assign issue_ready = rst_n && !flush && !hazard && !sat && !waw;
  assign fire        = issue_valid && issue_ready;
  assign inc         = fire && issue_writes;

  // Next-state counters plus derived busy mask, total and sticky underflow
  always_comb begin
    err_d   = err_q;
    busy_d  = '0;
    total_d = '0;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc && (issue_dest == 3'(r)) && wb_valid && (wb_dest == 3'(r))) begin
        cnt_d[r] = cnt_q[r];
      end else if (inc && (issue_dest == 3'(r))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (wb_valid && (wb_dest == 3'(r))) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
        else                err_d    = 1'b1;
      end
      busy_d[r] = (cnt_d[r] != '0);
      total_d   = total_d + TOT_W'(cnt_d[r]);
    end
  end

  // State registers; reset drops all pending writes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) cnt_q[r] <= '0;
      busy_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) cnt_q[r] <= cnt_d[r];
      busy_q  <= busy_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign busy_mask      = busy_q;
  assign inflight_total = total_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default CNT_W=2, WAW_STALL=0).
// A small reference model predicts issue_ready each cycle and pushes the
// expected registered outputs onto a queue; they are popped after the edge.
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_ready, issue_writes;
  logic [2:0] issue_dest, issue_src_a, issue_src_b, issue_memsr2, issue_use;
  logic       wb_valid;
  logic [2:0] wb_dest;
  logic       flush;
  logic [7:0] busy_mask;
  logic [4:0] inflight_total;
  logic       err_underflow;

  typedef struct packed {
    logic [7:0] busy;
    logic [4:0] total;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt [8];
  bit   merr;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  logic rdy;

  regfile_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_writes   (issue_writes),
    .issue_dest     (issue_dest),
    .issue_src_a    (issue_src_a),
    .issue_src_b    (issue_src_b),
    .issue_memsr2   (issue_memsr2),
    .issue_use      (issue_use),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .flush          (flush),
    .busy_mask      (busy_mask),
    .inflight_total (inflight_total),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_blocked(input int s);
    if (mcnt[s] == 0) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (mcnt[s] == 1 && wb_valid && int'(wb_dest) == s) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = (issue_use[0] && m_blocked(int'(issue_src_a))) ||
         (issue_use[1] && m_blocked(int'(issue_src_b))) ||
         (issue_use[2] && m_blocked(int'(issue_memsr2)));
    return rst_n && !flush && !hz && !(issue_writes && mcnt[issue_dest] == 3);
  endfunction

  // Advance the model by one clock using the currently driven inputs
  task automatic m_step();
    bit   inc;
    int   d, w, tot;
    exp_t e;
    inc = issue_valid && m_ready() && issue_writes;
    d   = int'(issue_dest);
    w   = int'(wb_dest);
    if (flush) begin
      for (int r = 0; r < 8; r++) mcnt[r] = 0;
    end else if (!(inc && wb_valid && d == w)) begin
      if (inc) mcnt[d]++;
      if (wb_valid) begin
        if (mcnt[w] > 0) mcnt[w]--;
        else             merr = 1'b1;
      end
    end
    tot    = 0;
    e.busy = '0;
    for (int r = 0; r < 8; r++) begin
      e.busy[r] = (mcnt[r] != 0);
      tot += mcnt[r];
    end
    e.total = 5'(tot);
    e.err   = merr;
    exp_q.push_back(e);
  endtask

  task automatic drive(input string tag, input bit v, input bit w, input int d,
                       input int a, input int b, input int m, input bit [2:0] u,
                       input bit wbv, input int wbd, input bit fl, output logic r);
    exp_t e;
    issue_valid  = v;
    issue_writes = w;
    issue_dest   = 3'(d);
    issue_src_a  = 3'(a);
    issue_src_b  = 3'(b);
    issue_memsr2 = 3'(m);
    issue_use    = u;
    wb_valid     = wbv;
    wb_dest      = 3'(wbd);
    flush        = fl;
    #1;
    r = issue_ready;
    chk({tag, "_ready"}, 32'(r), 32'(m_ready()));
    m_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_busy"},  32'(busy_mask),      32'(e.busy));
    chk({tag, "_total"}, 32'(inflight_total), 32'(e.total));
    chk({tag, "_err"},   32'(err_underflow),  32'(e.err));
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mcnt[r] = 0;
    merr = 1'b0;

    // T1: reset held with a valid instruction presented
    rst_n = 1'b0;
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 3'd1;
    issue_src_a = 3'd0; issue_src_b = 3'd0; issue_memsr2 = 3'd0; issue_use = 3'b000;
    wb_valid = 1'b0; wb_dest = 3'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_ready", 32'(issue_ready),    32'd0);
    chk("t1_busy",  32'(busy_mask),      32'h00);
    chk("t1_total", 32'(inflight_total), 32'd0);
    chk("t1_err",   32'(err_underflow),  32'd0);
    rst_n = 1'b1;

    // T2: RAW stall on R3
    drive("t2_add", 1, 1, 3, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    chk("t2_add_acc", 32'(rdy), 32'd1);
    chk("t2_busy08",  32'(busy_mask), 32'h08);
    drive("t2_raw0", 1, 0, 0, 3, 0, 0, 3'b001, 0, 0, 0, rdy);
    chk("t2_stall0", 32'(rdy), 32'd0);
    drive("t2_raw1", 1, 0, 0, 3, 0, 0, 3'b001, 0, 0, 0, rdy);
    chk("t2_stall1", 32'(rdy), 32'd0);
    drive("t2_wb", 1, 0, 0, 3, 0, 0, 3'b001, 1, 3, 0, rdy);
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t2_wbcycle", 32'(rdy), 32'd1);
`else
    chk("t2_wbcycle", 32'(rdy), 32'd0);
`endif
    drive("t2_after", 1, 0, 0, 3, 0, 0, 3'b001, 0, 0, 0, rdy);
    chk("t2_after_ready", 32'(rdy), 32'd1);

    // T3: saturation on R1
    for (int i = 0; i < 3; i++) begin
      drive("t3_w", 1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
      chk("t3_w_acc", 32'(rdy), 32'd1);
    end
    chk("t3_total3", 32'(inflight_total), 32'd3);
    drive("t3_w4", 1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    chk("t3_sat", 32'(rdy), 32'd0);
    drive("t3_w4wb", 1, 1, 1, 0, 0, 0, 3'b000, 1, 1, 0, rdy);
    chk("t3_sat_wb", 32'(rdy), 32'd0);
    drive("t3_w4b", 1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    chk("t3_w4_acc", 32'(rdy), 32'd1);
    chk("t3_total3b", 32'(inflight_total), 32'd3);

    // T4: simultaneous issue and writeback on R2
    drive("t4_flush", 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, rdy);
    drive("t4_w", 1, 1, 2, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    drive("t4_both", 1, 1, 2, 0, 0, 0, 3'b000, 1, 2, 0, rdy);
    chk("t4_both_acc", 32'(rdy), 32'd1);
    chk("t4_busy04", 32'(busy_mask), 32'h04);
    chk("t4_total1", 32'(inflight_total), 32'd1);

    // T5: flush with issue and writeback in the same cycle
    drive("t5_r0",  1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    drive("t5_r5a", 1, 1, 5, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    drive("t5_r5b", 1, 1, 5, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    chk("t5_total4", 32'(inflight_total), 32'd4);
    drive("t5_flush", 1, 1, 4, 0, 0, 0, 3'b000, 1, 5, 1, rdy);
    chk("t5_flush_ready", 32'(rdy), 32'd0);
    chk("t5_busy0",  32'(busy_mask),      32'h00);
    chk("t5_total0", 32'(inflight_total), 32'd0);
    chk("t5_err0",   32'(err_underflow),  32'd0);

    // T6: underflow is sticky through flush, cleared by reset
    drive("t6_uf", 0, 0, 0, 0, 0, 0, 3'b000, 1, 6, 0, rdy);
    chk("t6_err1", 32'(err_underflow), 32'd1);
    idle("t6_idle0");
    idle("t6_idle1");
    drive("t6_flush", 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, rdy);
    chk("t6_err_flush", 32'(err_underflow), 32'd1);
    drive("t6_w6", 1, 1, 6, 0, 0, 0, 3'b000, 0, 0, 0, rdy);
    chk("t6_busy40", 32'(busy_mask), 32'h40);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(busy_mask),      32'h00);
    chk("t6_rst_total", 32'(inflight_total), 32'd0);
    chk("t6_rst_err",   32'(err_underflow),  32'd0);
    chk("t6_rst_ready", 32'(issue_ready),    32'd0);
    for (int r = 0; r < 8; r++) mcnt[r] = 0;
    merr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive("t6_stale_wb", 0, 0, 0, 0, 0, 0, 3'b000, 1, 6, 0, rdy);
    chk("t6_stale_err", 32'(err_underflow), 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
